ternary_neuron_acc: RTL and testbench
=====================================

// Module: ternary_neuron_acc
// PURPOSE
//  Downstream consumer of the 22-input approximate popcount stage in a printed ternary neuron.
//  Per beat it takes two popcounts: matches on +1 weights (pc_pos) and on -1 weights (pc_neg).
//  Accumulates the signed difference pc_pos - pc_neg over N_BEATS beats per frame.
//  Compares the total against two thresholds and emits one ternary activation per frame over valid/ready.
// PARAMETERS
//  PC_W     5  popcount width; matches the 5-bit popcount22 output, values 0..22
//  N_BEATS  4  beats per frame, >=1; the beat counter is $clog2(N_BEATS+1) bits wide
//  ACC_W    8  signed accumulator, output-sum and threshold width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      beat valid
//  in_ready   out  1      beat accepted when in_valid & in_ready
//  pc_pos     in   PC_W   unsigned count of +1-weight matches
//  pc_neg     in   PC_W   unsigned count of -1-weight matches
//  in_last    in   1      producer's end-of-frame marker; checked only, never used for framing
//  thr_hi     in   ACC_W  signed upper threshold; sampled on the frame's first accepted beat
//  thr_lo     in   ACC_W  signed lower threshold; sampled on the frame's first accepted beat
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_act    out  2      ternary activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1
//  out_sum    out  ACC_W  signed saturated frame sum
//  out_sat    out  1      saturation occurred at least once in this frame
//  out_err    out  1      in_last did not match the beat count in this frame
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, acc=0, beat_cnt=0.
//   All outputs 0 except in_ready=1. Any partial frame is discarded.
//   Reset has priority over every other event.
//  FSM
//   IDLE -> ACC on accepted beat when N_BEATS>1.
//   IDLE -> OUT on accepted beat when N_BEATS==1.
//   ACC  -> OUT when the accepted beat is beat N_BEATS.
//   OUT  -> IDLE on out_valid & out_ready.
//  in_ready = (state != OUT). Only one frame is in flight; there is one bubble cycle between frames.
//  First beat: acc = sat(0 + d). Thresholds are latched; sat and err flags restart from this beat.
//  Later beats: acc = sat(acc + d), where d = zext(pc_pos) - zext(pc_neg), computed at ACC_W+1 bits.
//  Saturation
//   Result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   Any clamp sets the sticky sat flag for the current frame.
//  Frame end: the beat counter alone defines it.
//   err is set if in_last=1 on any beat other than beat N_BEATS.
//   err is also set if in_last=0 on beat N_BEATS.
//  Latency: out_valid=1 in the cycle after the final beat is accepted.
//   The result is registered at that edge.
//   Activation: sum > thr_hi -> +1; else sum < thr_lo -> -1; else 0.
//   Comparisons are signed. If thr_lo > thr_hi, the +1 test wins.
//  Held outputs: out_act, out_sum, out_sat and out_err stay stable while out_valid=1 and out_ready=0.
//   They keep their last value after the handshake; only out_valid drops.
//  Inputs are ignored while in_ready=0. Data presented then is not consumed.
//  Simultaneous events: in OUT with out_ready=1 and in_valid=1, the beat is not taken.
//   It is accepted in the IDLE cycle that follows.
//  pc_pos/pc_neg values above 22 are legal and are summed arithmetically.
// STRUCTURE
//  Package ternary_neuron_pkg:
//   act_t encoding constants ACT_POS=2'b01, ACT_ZERO=2'b00, ACT_NEG=2'b11
//   state_t enum {IDLE, ACC, OUT}
//  Sub-module sat_add_s: parameterised ACC_W signed saturating adder with a sat output.
//   It is instantiated once for the accumulate path.
//  Remaining logic stays inline: FSM, beat counter, threshold latch, comparator, output registers.
// TESTING
//  1. Defaults, 4 beats of pos=22, neg=0, thr_hi=50, thr_lo=-50
//     -> out_sum=88, out_act=01, sat=0, err=0.
//  2. 4 beats of pos=3, neg=10 with thr_lo=-20
//     -> out_sum=-28, act=11.
//     Then sum=-20 with thr_lo=-20 -> act=00 (strict compare).
//  3. N_BEATS=8, every beat pos=22, neg=0
//     -> out_sum=127, out_sat=1.
//     Next frame with pos=neg=1 -> sum=0, sat=0 (flags cleared).
//  4. Hold out_ready=0 for 5 cycles after out_valid
//     -> outputs stable, in_ready=0, offered beats not consumed.
//     Then out_ready=1 -> IDLE next cycle.
//  5. rst_n=0 for 1 cycle after beat 2 of a frame
//     -> in_ready=1, out_valid=0.
//     A fresh 4-beat frame then gives a sum of its own beats only.
//  6. in_last=1 on beat 2 of 4 -> out_err=1 at frame end, framing unchanged.

Source files
------------

// File: rtl/ternary_neuron_pkg.sv
// Shared types for the ternary neuron accumulator: activation encoding and FSM states.
package ternary_neuron_pkg;

    typedef logic [1:0] act_t;

    localparam act_t ACT_POS  = 2'b01;
    localparam act_t ACT_ZERO = 2'b00;
    localparam act_t ACT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/ternary_neuron_acc_sat_add.sv
// Signed saturating adder: ACC_W-bit accumulator plus an (ACC_W+1)-bit signed delta.
module sat_add_s #(
    parameter int ACC_W = 8
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W+1:0] MAXV = (ACC_W+2)'((1 << (ACC_W-1)) - 1);
    localparam logic signed [ACC_W+1:0] MINV = -MAXV - (ACC_W+2)'(1);

    logic signed [ACC_W+1:0] full;

    always_comb begin
        full  = {{2{a_i[ACC_W-1]}}, a_i} + {b_i[ACC_W], b_i};
        sum_o = full[ACC_W-1:0];
        sat_o = 1'b0;
        if (full > MAXV) begin
            sum_o = {1'b0, {(ACC_W-1){1'b1}}};
            sat_o = 1'b1;
        end else if (full < MINV) begin
            sum_o = {1'b1, {(ACC_W-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulates pc_pos - pc_neg over N_BEATS beats per frame and emits a thresholded
// ternary activation with saturation and framing-error flags over valid/ready.
module ternary_neuron_acc
    import ternary_neuron_pkg::*;
#(
    parameter int PC_W    = 5,
    parameter int N_BEATS = 4,
    parameter int ACC_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         pc_pos,
    input  logic [PC_W-1:0]         pc_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_sat,
    output logic                    out_err
);

    localparam int CNT_W = $clog2(N_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d, beat_num;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
    logic signed [ACC_W-1:0] thr_hi_eff, thr_lo_eff;
    logic signed [ACC_W-1:0] add_a, add_sum;
    logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
    logic signed [ACC_W:0]   delta;
    act_t                    out_act_q, out_act_d;
    logic                    add_sat;
    logic                    sat_q, sat_d, err_q, err_d;
    logic                    out_sat_q, out_sat_d, out_err_q, out_err_d;
    logic                    accept, first, final_beat;

    assign in_ready   = (state_q != OUT);
    assign out_valid  = (state_q == OUT);
    assign out_act    = out_act_q;
    assign out_sum    = out_sum_q;
    assign out_sat    = out_sat_q;
    assign out_err    = out_err_q;

    assign accept     = in_valid & in_ready;
    assign first      = (state_q == IDLE);
    assign beat_num   = first ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
    assign final_beat = (beat_num == LAST_BEAT);

    // Zero-extend both counts before subtracting so values above 22 still sum exactly.
    assign delta      = $signed((ACC_W+1)'(pc_pos)) - $signed((ACC_W+1)'(pc_neg));
    assign add_a      = first ? '0 : acc_q;
    assign thr_hi_eff = first ? thr_hi : thr_hi_q;
    assign thr_lo_eff = first ? thr_lo : thr_lo_q;

    sat_add_s #(.ACC_W(ACC_W)) u_sat_add (
        .a_i   (add_a),
        .b_i   (delta),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = final_beat ? OUT : ACC;
            ACC:     if (accept && final_beat) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        thr_hi_d   = thr_hi_q;
        thr_lo_d   = thr_lo_q;
        sat_d      = sat_q;
        err_d      = err_q;
        out_sum_d  = out_sum_q;
        out_act_d  = out_act_q;
        out_sat_d  = out_sat_q;
        out_err_d  = out_err_q;
        if (accept) begin
            acc_d      = add_sum;
            beat_cnt_d = final_beat ? '0 : beat_num;
            sat_d      = (first ? 1'b0 : sat_q) | add_sat;
            err_d      = (first ? 1'b0 : err_q) | (in_last != final_beat);
            if (first) begin
                thr_hi_d = thr_hi;
                thr_lo_d = thr_lo;
            end
            if (final_beat) begin
                out_sum_d = add_sum;
                out_sat_d = sat_d;
                out_err_d = err_d;
                if (add_sum > thr_hi_eff)      out_act_d = ACT_POS;
                else if (add_sum < thr_lo_eff) out_act_d = ACT_NEG;
                else                           out_act_d = ACT_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            thr_hi_q   <= '0;
            thr_lo_q   <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            out_sum_q  <= '0;
            out_act_q  <= ACT_ZERO;
            out_sat_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            thr_hi_q   <= thr_hi_d;
            thr_lo_q   <= thr_lo_d;
            sat_q      <= sat_d;
            err_q      <= err_d;
            out_sum_q  <= out_sum_d;
            out_act_q  <= out_act_d;
            out_sat_q  <= out_sat_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Scoreboard bench for ternary_neuron_acc: a 4-beat and an 8-beat instance share stimulus.
module tb_ternary_neuron_acc;
    import ternary_neuron_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_last, out_ready;
    logic [4:0]        pc_pos, pc_neg;
    logic signed [7:0] thr_hi, thr_lo;
    int                sel;

    logic              iv4, rdy4, ov4, sat4, err4;
    logic [1:0]        act4;
    logic signed [7:0] sum4;
    logic              iv8, rdy8, ov8, sat8, err8;
    logic [1:0]        act8;
    logic signed [7:0] sum8;

    assign iv4 = in_valid && (sel == 0);
    assign iv8 = in_valid && (sel == 1);

    always #5 clk = ~clk;

    ternary_neuron_acc #(.PC_W(5), .N_BEATS(4), .ACC_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .pc_pos(pc_pos), .pc_neg(pc_neg), .in_last(in_last),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(ov4), .out_ready(out_ready),
        .out_act(act4), .out_sum(sum4), .out_sat(sat4), .out_err(err4)
    );

    ternary_neuron_acc #(.PC_W(5), .N_BEATS(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
        .pc_pos(pc_pos), .pc_neg(pc_neg), .in_last(in_last),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(ov8), .out_ready(out_ready),
        .out_act(act8), .out_sum(sum8), .out_sat(sat8), .out_err(err8)
    );

    typedef struct packed {
        logic [1:0]        act;
        logic signed [7:0] sum;
        logic              sat;
        logic              err;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   vecs = 0;
    int   miss = 0;

    function automatic exp_t mk(input logic [1:0] a, input int s, input bit sa, input bit er);
        exp_t m;
        m.act = a;
        m.sum = 8'(s);
        m.sat = sa;
        m.err = er;
        return m;
    endfunction

    task automatic cmp(input string name, input exp_t got, input exp_t want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got act=%b sum=%0d sat=%b err=%b, want act=%b sum=%0d sat=%b err=%b",
                     name, got.act, got.sum, got.sat, got.err, want.act, want.sum, want.sat, want.err);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitors: a result is consumed whenever out_valid & out_ready is seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ov4 && out_ready) begin
            if (q4.size() == 0) begin
                vecs++; miss++;
                $display("FAIL mon4: got unexpected result sum=%0d, want none", sum4);
            end else begin
                cmp("frame4", mk(act4, int'(sum4), sat4, err4), q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && out_ready) begin
            if (q8.size() == 0) begin
                vecs++; miss++;
                $display("FAIL mon8: got unexpected result sum=%0d, want none", sum8);
            end else begin
                cmp("frame8", mk(act8, int'(sum8), sat8, err8), q8.pop_front());
            end
        end
    end

    // Stimulus changes 1 time unit after the rising edge; a beat is offered until accepted.
    task automatic beat(input int s, input int p, input int n, input bit last);
        int t = 0;
        sel = s; pc_pos = 5'(p); pc_neg = 5'(n); in_last = last; in_valid = 1'b1;
        while (!(s == 1 ? rdy8 : rdy4)) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
                vecs++; miss++;
                $display("FAIL beat_timeout: got in_ready=0 for %0d cycles, want 1", t);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic frame(input int s, input int n, input int p, input int ng, input exp_t e);
        if (s == 1) q8.push_back(e); else q4.push_back(e);
        for (int i = 1; i <= n; i++) beat(s, p, ng, i == n);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
        pc_pos = '0; pc_neg = '0; thr_hi = 8'sd50; thr_lo = -8'sd50; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy4", rdy4, 1); chk("rst_ov4", ov4, 0);
        chk("rst_sum4", sum4, 0); chk("rst_act4", act4, 0);
        chk("rst_sat4", sat4, 0); chk("rst_err4", err4, 0);
        chk("rst_rdy8", rdy8, 1); chk("rst_ov8", ov8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        frame(0, 4, 22, 0, mk(ACT_POS, 88, 0, 0));
        thr_lo = -8'sd20;
        frame(0, 4, 3, 10, mk(ACT_NEG, -28, 0, 0));
        frame(0, 4, 0, 5, mk(ACT_ZERO, -20, 0, 0));
        thr_hi = -8'sd10; thr_lo = 8'sd10;
        frame(0, 4, 1, 1, mk(ACT_POS, 0, 0, 0));
        thr_hi = 8'sd8; thr_lo = -8'sd50;
        frame(0, 4, 2, 0, mk(ACT_ZERO, 8, 0, 0));
        thr_hi = 8'sd50;
        frame(0, 4, 31, 0, mk(ACT_POS, 124, 0, 0));

        frame(1, 8, 22, 0, mk(ACT_POS, 127, 1, 0));
        frame(1, 8, 1, 1, mk(ACT_ZERO, 0, 0, 0));
        frame(1, 8, 0, 22, mk(ACT_NEG, -128, 1, 0));
        q8.push_back(mk(ACT_POS, 83, 1, 0));
        for (int i = 0; i < 6; i++) beat(1, 22, 0, 0);
        beat(1, 0, 22, 0);
        beat(1, 0, 22, 1);
        in_valid = 1'b0;

        // Thresholds must come from the first beat, not from later beats.
        thr_hi = 8'sd100; thr_lo = -8'sd50;
        q4.push_back(mk(ACT_ZERO, 20, 0, 0));
        beat(0, 5, 0, 0);
        thr_hi = 8'sd0; thr_lo = 8'sd100;
        beat(0, 5, 0, 0); beat(0, 5, 0, 0); beat(0, 5, 0, 1);
        in_valid = 1'b0;
        thr_hi = 8'sd50; thr_lo = -8'sd50;

        q4.push_back(mk(ACT_ZERO, 32, 0, 0));
        for (int i = 1; i <= 4; i++) beat(0, 10, 2, i == 4);
        out_ready = 1'b0;
        sel = 0; pc_pos = 5'd5; pc_neg = 5'd0; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ov", ov4, 1); chk("hold_sum", sum4, 32); chk("hold_rdy", rdy4, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_ov", ov4, 0); chk("post_rdy", rdy4, 1); chk("post_sum", sum4, 32);
        q4.push_back(mk(ACT_ZERO, 8, 0, 0));
        beat(0, 5, 0, 0); beat(0, 1, 0, 0); beat(0, 1, 0, 0); beat(0, 1, 0, 1);
        in_valid = 1'b0;

        thr_hi = 8'sd3; thr_lo = -8'sd3;
        beat(0, 20, 0, 0); beat(0, 20, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rdy", rdy4, 1); chk("mid_rst_ov", ov4, 0); chk("mid_rst_sum", sum4, 0);
        rst_n = 1'b1;
        frame(0, 4, 2, 1, mk(ACT_POS, 4, 0, 0));

        thr_hi = 8'sd50; thr_lo = -8'sd50;
        q4.push_back(mk(ACT_ZERO, 4, 0, 1));
        beat(0, 1, 0, 0); beat(0, 1, 0, 1); beat(0, 1, 0, 0); beat(0, 1, 0, 1);
        in_valid = 1'b0;
        frame(0, 4, 1, 0, mk(ACT_ZERO, 4, 0, 0));
        q4.push_back(mk(ACT_ZERO, 4, 0, 1));
        for (int i = 0; i < 4; i++) beat(0, 1, 0, 0);
        in_valid = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("drain_q4", q4.size(), 0);
        chk("drain_q8", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
